psone_pad_device: RTL and testbench

- Responder end of the PlayStation controller link: emulates a digital pad (ID 0x41) on the CS/CLK/CMD/DATA/ACK bus.
- Slave to an external console or to the in-house host controller. Samples all bus inputs through synchronizers in the iCLK domain.
- Returns a button snapshot and pulses ACK after each byte. Exposes every received command byte to local logic (UART bridge, debug).

---
 rtl/psone_pkg.sv | 36 +++
 rtl/psone_sync_edge.sv | 36 +++
 rtl/psone_pad_device.sv | 195 +++++++++++++++++++
 tb/tb_psone_pad_device.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/psone_pkg.sv
// Shared constants, FSM encoding and reply-table helper for the PlayStation pad link.
package psone_pkg;

    localparam logic [7:0] PSX_CMD_START  = 8'h01;
    localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
    localparam logic [7:0] PSX_PAD_MARK   = 8'h5A;
    localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACK_WAIT,
        ST_ACK_PULSE,
        ST_TAIL,
        ST_IGNORE
    } pad_state_t;

    // Reply byte for a given packet index; anything past the packet length idles high.
    function automatic logic [7:0] psx_reply(input logic [3:0] idx, input logic [15:0] snap,
                                             input logic [7:0] id, input logic [4:0] nbytes);
        logic [7:0] r;
        r = PSX_IDLE_BYTE;
        if ({1'b0, idx} < nbytes) begin
            case (idx)
                4'd1:    r = id;
                4'd2:    r = PSX_PAD_MARK;
                4'd3:    r = snap[7:0];
                4'd4:    r = snap[15:8];
                default: r = PSX_IDLE_BYTE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/psone_sync_edge.sv
// Two-flop synchronizer with a third compare flop producing rise/fall strobes.
module psone_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic       s1, s2, s3;
    logic [2:0] primed;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            s1     <= RST_VAL;
            s2     <= RST_VAL;
            s3     <= RST_VAL;
            primed <= '0;
        end else begin
            s1     <= din;
            s2     <= s1;
            s3     <= s2;
            primed <= {primed[1:0], 1'b1};
        end
    end

    // Edges are masked until the compare flop holds a real sample, so a pin
    // already low at reset release is not reported as a falling edge.
    assign sync = s2;
    assign rise = primed[2] & s2 & ~s3;
    assign fall = primed[2] & ~s2 & s3;

endmodule

// File: rtl/psone_pad_device.sv
// Digital pad responder on the PlayStation CS/CLK/CMD/DATA/ACK bus, iCLK-domain oversampled.
module psone_pad_device
    import psone_pkg::*;
#(
    parameter logic [7:0]  ID_BYTE   = PSX_ID_DIGITAL,
    parameter int          NUM_BYTES = 5,
    parameter logic [11:0] ACK_DELAY = 12'd100,
    parameter logic [11:0] ACK_WIDTH = 12'd100
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iCS,
    input  logic        iSCK,
    input  logic        iCMD,
    output logic        oDAT,
    output logic        oDAT_OE,
    output logic        oACK,
    input  logic [15:0] iBUTTONS,
    output logic [7:0]  oCMD_BYTE,
    output logic [3:0]  oCMD_IDX,
    output logic        oCMD_VALID,
    output logic        oBUSY
);

    localparam logic [4:0] NB = 5'(NUM_BYTES);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic [1:0] cmd_ff;
    logic unused_sync;

    psone_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .iCLK(iCLK), .iRESET(iRESET), .din(iCS),
        .sync(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    psone_sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
        .iCLK(iCLK), .iRESET(iRESET), .din(iSCK),
        .sync(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    assign unused_sync = cs_lvl ^ sck_lvl;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) cmd_ff <= 2'b11;
        else         cmd_ff <= {cmd_ff[0], iCMD};
    end

    pad_state_t  state, state_n;
    logic [3:0]  idx, idx_n, bitcnt, bitcnt_n, cmd_idx_n;
    logic [7:0]  tx, tx_n, rx, rx_n, rx_shift, cmd_byte_n;
    logic [15:0] snap, snap_n;
    logic [11:0] cnt, cnt_n;
    logic        dat_n, dat_oe_n, ack_n, cmd_valid_n, busy_n;
    logic        byte_done, abort;
    logic [3:0]  idx_inc;

    assign rx_shift = {cmd_ff[1], rx[7:1]};
    assign idx_inc  = (idx == 4'd15) ? 4'd15 : idx + 4'd1;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state      <= ST_IDLE;
            idx        <= '0;
            bitcnt     <= '0;
            tx         <= PSX_IDLE_BYTE;
            rx         <= '0;
            snap       <= '0;
            cnt        <= '0;
            oDAT       <= 1'b1;
            oDAT_OE    <= 1'b0;
            oACK       <= 1'b1;
            oCMD_BYTE  <= '0;
            oCMD_IDX   <= '0;
            oCMD_VALID <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            bitcnt     <= bitcnt_n;
            tx         <= tx_n;
            rx         <= rx_n;
            snap       <= snap_n;
            cnt        <= cnt_n;
            oDAT       <= dat_n;
            oDAT_OE    <= dat_oe_n;
            oACK       <= ack_n;
            oCMD_BYTE  <= cmd_byte_n;
            oCMD_IDX   <= cmd_idx_n;
            oCMD_VALID <= cmd_valid_n;
            oBUSY      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        bitcnt_n    = bitcnt;
        tx_n        = tx;
        rx_n        = rx;
        snap_n      = snap;
        cnt_n       = cnt;
        dat_n       = oDAT;
        dat_oe_n    = oDAT_OE;
        ack_n       = oACK;
        busy_n      = oBUSY;
        cmd_byte_n  = oCMD_BYTE;
        cmd_idx_n   = oCMD_IDX;
        cmd_valid_n = 1'b0;
        byte_done   = 1'b0;
        abort       = 1'b0;

        case (state)
            ST_IDLE: if (cs_fall) begin
                idx_n    = '0;
                bitcnt_n = '0;
                snap_n   = iBUTTONS;
                tx_n     = psx_reply(4'd0, iBUTTONS, ID_BYTE, NB);
                dat_n    = 1'b1;
                dat_oe_n = 1'b1;
                busy_n   = 1'b1;
                state_n  = ST_SHIFT;
            end
            ST_ACK_WAIT: begin
                if (cnt == '0) begin
                    ack_n   = 1'b0;
                    cnt_n   = ACK_WIDTH;
                    state_n = ST_ACK_PULSE;
                end else begin
                    cnt_n = cnt - 12'd1;
                end
            end
            ST_ACK_PULSE: begin
                if (cnt <= 12'd1) begin
                    ack_n   = 1'b1;
                    state_n = ST_SHIFT;
                end else begin
                    cnt_n = cnt - 12'd1;
                end
            end
            default: ;
        endcase

        // Bit engine runs in every active state so a host that does not wait for ACK still works.
        if (state inside {ST_SHIFT, ST_ACK_WAIT, ST_ACK_PULSE, ST_TAIL}) begin
            if (sck_fall) begin
                dat_n = tx[0];
                tx_n  = {1'b1, tx[7:1]};
            end
            if (sck_rise) begin
                rx_n      = rx_shift;
                bitcnt_n  = bitcnt + 4'd1;
                byte_done = (bitcnt == 4'd7);
            end
        end

        if (byte_done) begin
            cmd_valid_n = 1'b1;
            cmd_byte_n  = rx_shift;
            cmd_idx_n   = idx;
            bitcnt_n    = '0;
            ack_n       = 1'b1;
            abort = ((idx == 4'd0) && (rx_shift != PSX_CMD_START)) ||
                    ((idx == 4'd1) && (rx_shift != PSX_CMD_POLL));
            if (abort) begin
                state_n  = ST_IGNORE;
                dat_n    = 1'b1;
                dat_oe_n = 1'b0;
                busy_n   = 1'b0;
            end else begin
                idx_n = idx_inc;
                tx_n  = psx_reply(idx_inc, snap, ID_BYTE, NB);
                if (({1'b0, idx} + 5'd1) < NB) begin
                    cnt_n   = ACK_DELAY;
                    state_n = ST_ACK_WAIT;
                end else begin
                    state_n = ST_TAIL;
                end
            end
        end

        // Deselect wins over everything, including a half-received byte.
        if (cs_rise) begin
            state_n     = ST_IDLE;
            dat_n       = 1'b1;
            dat_oe_n    = 1'b0;
            ack_n       = 1'b1;
            busy_n      = 1'b0;
            cmd_valid_n = 1'b0;
            cmd_byte_n  = oCMD_BYTE;
            cmd_idx_n   = oCMD_IDX;
        end
    end

endmodule

// File: tb/tb_psone_pad_device.sv
// Directed bench: bit-banged host frames against the pad responder with hand-computed replies.
module tb_psone_pad_device;

    localparam int HALF = 8;
    localparam int GAP  = 24;

    logic        iCLK, iRESET, iCS, iSCK, iCMD;
    logic        oDAT, oDAT_OE, oACK, oCMD_VALID, oBUSY;
    logic [15:0] iBUTTONS;
    logic [7:0]  oCMD_BYTE;
    logic [3:0]  oCMD_IDX;

    psone_pad_device #(
        .ID_BYTE(8'h41), .NUM_BYTES(5), .ACK_DELAY(12'd6), .ACK_WIDTH(12'd10)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iCS(iCS), .iSCK(iSCK), .iCMD(iCMD),
        .oDAT(oDAT), .oDAT_OE(oDAT_OE), .oACK(oACK), .iBUTTONS(iBUTTONS),
        .oCMD_BYTE(oCMD_BYTE), .oCMD_IDX(oCMD_IDX), .oCMD_VALID(oCMD_VALID), .oBUSY(oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: ACK pulse count/width and a log of command strobes.
    logic       prev_ack = 1'b1;
    int         ack_falls = 0, cur_w = 0, last_w = 0, nvalid = 0;
    logic [3:0] vidx  [0:255];
    logic [7:0] vbyte [0:255];
    logic [3:0] last_idx = '0;

    always @(negedge iCLK) begin
        if (!oACK) cur_w = prev_ack ? 1 : cur_w + 1;
        if (prev_ack && !oACK) ack_falls++;
        if (!prev_ack && oACK) last_w = cur_w;
        prev_ack = oACK;
        if (oCMD_VALID) begin
            vidx[nvalid % 256]  = oCMD_IDX;
            vbyte[nvalid % 256] = oCMD_BYTE;
            last_idx = oCMD_IDX;
            nvalid++;
        end
    end

    function automatic logic line_val();
        return !(oDAT_OE && !oDAT);
    endfunction

    task automatic send_bits(input logic [7:0] c, input int nb, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < nb; i++) begin
            iSCK = 1'b0;
            iCMD = c[i];
            repeat (HALF) @(negedge iCLK);
            r[i] = line_val();
            iSCK = 1'b1;
            repeat (HALF) @(negedge iCLK);
        end
    endtask

    logic [7:0] cmds [0:8];
    logic [7:0] reps [0:8];

    task automatic run_frame(input int n, input int chg_at, input logic [15:0] chg_val);
        logic [7:0] r;
        iCS = 1'b0;
        repeat (10) @(negedge iCLK);
        chk("busy_sel", oBUSY, 1'b1);
        for (int k = 0; k < n; k++) begin
            if (k == chg_at) iBUTTONS = chg_val;
            send_bits(cmds[k], 8, r);
            reps[k] = r;
            repeat (GAP) @(negedge iCLK);
        end
        iCS = 1'b1;
        repeat (10) @(negedge iCLK);
    endtask

    task automatic set_poll(input int n);
        for (int k = 0; k < 9; k++) cmds[k] = 8'h00;
        cmds[0] = 8'h01;
        cmds[1] = 8'h42;
        if (n < 2) cmds[1] = 8'h00;
    endtask

    int a0, v0;
    logic [7:0] r;

    initial begin
        iRESET = 1'b0; iCS = 1'b0; iSCK = 1'b1; iCMD = 1'b1; iBUTTONS = 16'hFFFF;
        repeat (3) @(negedge iCLK);
        chk("rst_dat", oDAT, 1'b1);
        chk("rst_oe", oDAT_OE, 1'b0);
        chk("rst_ack", oACK, 1'b1);
        chk("rst_byte", oCMD_BYTE, 8'h00);
        chk("rst_idx", oCMD_IDX, 4'h0);
        chk("rst_valid", oCMD_VALID, 1'b0);
        chk("rst_busy", oBUSY, 1'b0);
        iRESET = 1'b1;
        repeat (10) @(negedge iCLK);
        chk("cs_low_rel_busy", oBUSY, 1'b0);
        chk("cs_low_rel_oe", oDAT_OE, 1'b0);
        iCS = 1'b1;
        repeat (10) @(negedge iCLK);

        // Digital poll with START pressed
        iBUTTONS = 16'hFFF7;
        set_poll(5);
        a0 = ack_falls; v0 = nvalid;
        run_frame(5, -1, 16'h0);
        chk("poll_r0", reps[0], 8'hFF);
        chk("poll_r1", reps[1], 8'h41);
        chk("poll_r2", reps[2], 8'h5A);
        chk("poll_r3", reps[3], 8'hF7);
        chk("poll_r4", reps[4], 8'hFF);
        chk("poll_acks", ack_falls - a0, 4);
        chk("poll_ackw", last_w, 10);
        chk("poll_nvalid", nvalid - v0, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("poll_vidx%0d", k), vidx[(v0 + k) % 256], k);
            chk($sformatf("poll_vbyte%0d", k), vbyte[(v0 + k) % 256], cmds[k]);
        end
        chk("poll_end_busy", oBUSY, 1'b0);

        // Wrong address
        a0 = ack_falls; v0 = nvalid;
        iCS = 1'b0;
        repeat (10) @(negedge iCLK);
        send_bits(8'h81, 8, r);
        chk("wa_r0", r, 8'hFF);
        repeat (4) @(negedge iCLK);
        chk("wa_oe", oDAT_OE, 1'b0);
        chk("wa_busy", oBUSY, 1'b0);
        for (int k = 1; k < 5; k++) begin
            send_bits(8'h42, 8, r);
            chk($sformatf("wa_r%0d", k), r, 8'hFF);
            chk($sformatf("wa_oe%0d", k), oDAT_OE, 1'b0);
            repeat (GAP) @(negedge iCLK);
        end
        iCS = 1'b1;
        repeat (10) @(negedge iCLK);
        chk("wa_acks", ack_falls - a0, 0);
        chk("wa_nvalid", nvalid - v0, 1);
        chk("wa_byte", vbyte[v0 % 256], 8'h81);

        // 9-byte host frame
        set_poll(9);
        a0 = ack_falls; v0 = nvalid;
        run_frame(9, -1, 16'h0);
        for (int k = 5; k < 9; k++) chk($sformatf("long_r%0d", k), reps[k], 8'hFF);
        chk("long_acks", ack_falls - a0, 4);
        chk("long_nvalid", nvalid - v0, 9);
        chk("long_lastidx", last_idx, 4'd8);

        // Abort after 4 SCK of byte 2
        v0 = nvalid;
        iCS = 1'b0;
        repeat (10) @(negedge iCLK);
        send_bits(8'h01, 8, r); repeat (GAP) @(negedge iCLK);
        send_bits(8'h42, 8, r); repeat (GAP) @(negedge iCLK);
        send_bits(8'h00, 4, r);
        iCS = 1'b1;
        repeat (4) @(negedge iCLK);
        chk("ab1_ack", oACK, 1'b1);
        chk("ab1_oe", oDAT_OE, 1'b0);
        repeat (10) @(negedge iCLK);
        chk("ab1_nvalid", nvalid - v0, 2);

        // Abort during ACK pulse
        iCS = 1'b0;
        repeat (10) @(negedge iCLK);
        send_bits(8'h01, 8, r);
        for (int i = 0; i < 200 && oACK; i++) @(negedge iCLK);
        chk("ab2_ack_seen", oACK, 1'b0);
        iCS = 1'b1;
        repeat (4) @(negedge iCLK);
        chk("ab2_ack", oACK, 1'b1);
        chk("ab2_oe", oDAT_OE, 1'b0);
        repeat (10) @(negedge iCLK);

        // Next frame restarts at index 0
        set_poll(5);
        v0 = nvalid;
        run_frame(5, -1, 16'h0);
        chk("ab_next_vidx0", vidx[v0 % 256], 4'd0);
        chk("ab_next_r1", reps[1], 8'h41);
        chk("ab_next_r3", reps[3], 8'hF7);

        // Snapshot holds across a mid-frame button change
        iBUTTONS = 16'hFFFF;
        run_frame(5, 2, 16'h0000);
        chk("snap_r3", reps[3], 8'hFF);
        chk("snap_r4", reps[4], 8'hFF);
        run_frame(5, -1, 16'h0);
        chk("snap_next_r3", reps[3], 8'h00);
        chk("snap_next_r4", reps[4], 8'h00);

        // Async reset in the middle of a byte
        iBUTTONS = 16'h1234;
        iCS = 1'b0;
        repeat (10) @(negedge iCLK);
        send_bits(8'h01, 8, r);
        send_bits(8'h42, 3, r);
        #2 iRESET = 1'b0;
        #1;
        chk("arst_dat", oDAT, 1'b1);
        chk("arst_oe", oDAT_OE, 1'b0);
        chk("arst_ack", oACK, 1'b1);
        chk("arst_busy", oBUSY, 1'b0);
        chk("arst_byte", oCMD_BYTE, 8'h00);
        chk("arst_idx", oCMD_IDX, 4'h0);
        chk("arst_valid", oCMD_VALID, 1'b0);
        iCS = 1'b1; iSCK = 1'b1;
        repeat (4) @(negedge iCLK);
        iRESET = 1'b1;
        repeat (10) @(negedge iCLK);
        a0 = ack_falls;
        run_frame(5, -1, 16'h0);
        chk("post_r1", reps[1], 8'h41);
        chk("post_r2", reps[2], 8'h5A);
        chk("post_r3", reps[3], 8'h34);
        chk("post_r4", reps[4], 8'h12);
        chk("post_acks", ack_falls - a0, 4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
